// File: rtl/instr_load_ctrl.sv
// rtl/instr_load_ctrl.sv - instruction loader and pipeline enable gate
// Streams words into IMEM while the pipeline is held in reset, then runs or single-steps it until HALT.
module instr_load_ctrl #(
  parameter int unsigned          ADDR_W    = 8,
  parameter int unsigned          DATA_W    = 32,
  parameter logic [DATA_W-1:0]    HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_instruction_in,
  input  logic              i_flag_i,
  input  logic              i_flag_step,
  input  logic              i_mode_cont,
  input  logic              i_pipe_halted,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [DATA_W-1:0] o_imem_data,
  output logic              o_pipe_reset,
  output logic              o_pipe_en,
  output logic [ADDR_W:0]   o_load_count,
  output logic              o_load_err,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'b00,
    S_READY = 2'b01,
    S_RUN   = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_LAST  = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_pipe_reset;
  logic                r_pipe_en;
  logic                r_load_err;
  logic                r_step_q;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [ADDR_W:0]     w_count_nxt;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_pipe_en_nxt;
  logic                w_load_err_nxt;
  logic                w_step_edge;

  assign w_step_edge = i_flag_step & ~r_step_q;

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_count_nxt    = r_count;
    w_we_nxt       = 1'b0;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_pipe_en_nxt  = 1'b0;
    w_load_err_nxt = r_load_err;

    case (r_state)
      S_LOAD: begin
        if (i_flag_i) begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_ptr;
          w_data_nxt  = i_instruction_in;
          w_ptr_nxt   = r_ptr + PTR_ONE;
          w_count_nxt = r_count + COUNT_ONE;
          // A full memory ends the stream just like HALT; the pointer never wraps into use.
          if ((i_instruction_in == HALT_WORD) || (r_ptr == PTR_LAST)) begin
            w_state_nxt = S_READY;
          end
        end
      end
      S_READY: begin
        // Halt has priority over both free-run entry and a pending step.
        if (i_pipe_halted) begin
          w_state_nxt = S_DONE;
        end else if (i_mode_cont) begin
          w_state_nxt   = S_RUN;
          w_pipe_en_nxt = 1'b1;
        end else begin
          w_pipe_en_nxt = w_step_edge;
        end
      end
      S_RUN: begin
        if (i_pipe_halted) begin
          w_state_nxt = S_DONE;
        end else begin
          w_pipe_en_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_DONE;
      end
    endcase

    if ((r_state != S_LOAD) && i_flag_i) begin
      w_load_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_LOAD;
      r_ptr        <= '0;
      r_count      <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_pipe_reset <= 1'b1;
      r_pipe_en    <= 1'b0;
      r_load_err   <= 1'b0;
      r_step_q     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_count      <= w_count_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_pipe_reset <= (w_state_nxt == S_LOAD);
      r_pipe_en    <= w_pipe_en_nxt;
      r_load_err   <= w_load_err_nxt;
      r_step_q     <= i_flag_step;
    end
  end

  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_data  = r_data;
  assign o_pipe_reset = r_pipe_reset;
  assign o_pipe_en    = r_pipe_en;
  assign o_load_count = r_count;
  assign o_load_err   = r_load_err;
  assign o_state      = r_state;

endmodule

// File: tb/tb_instr_load_ctrl.sv
// tb/tb_instr_load_ctrl.sv - directed scoreboard bench for instr_load_ctrl
// Expected IMEM writes are queued when a word is driven and popped when the DUT writes.
module tb_instr_load_ctrl;

  logic        clk;
  int          checks;
  int          errors;
  int          en_cnt;

  logic        rst1, flag_i1, step1, mode1, halted1;
  logic [31:0] instr1;
  logic        we1, pipe_reset1, pipe_en1, err1;
  logic [7:0]  addr1;
  logic [31:0] data1;
  logic [8:0]  count1;
  logic [1:0]  state1;

  logic        rst2, flag_i2, step2, mode2, halted2;
  logic [31:0] instr2;
  logic        we2, pipe_reset2, pipe_en2, err2;
  logic [1:0]  addr2;
  logic [31:0] data2;
  logic [2:0]  count2;
  logic [1:0]  state2;

  logic [39:0] q1[$];
  logic [33:0] q2[$];

  instr_load_ctrl u_dut (
    .i_clk(clk), .i_reset(rst1), .i_instruction_in(instr1), .i_flag_i(flag_i1),
    .i_flag_step(step1), .i_mode_cont(mode1), .i_pipe_halted(halted1),
    .o_imem_we(we1), .o_imem_addr(addr1), .o_imem_data(data1),
    .o_pipe_reset(pipe_reset1), .o_pipe_en(pipe_en1), .o_load_count(count1),
    .o_load_err(err1), .o_state(state1)
  );

  instr_load_ctrl #(.ADDR_W(2)) u_dut_small (
    .i_clk(clk), .i_reset(rst2), .i_instruction_in(instr2), .i_flag_i(flag_i2),
    .i_flag_step(step2), .i_mode_cont(mode2), .i_pipe_halted(halted2),
    .o_imem_we(we2), .o_imem_addr(addr2), .o_imem_data(data2),
    .o_pipe_reset(pipe_reset2), .o_pipe_en(pipe_en2), .o_load_count(count2),
    .o_load_err(err2), .o_state(state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (we1 === 1'b1) begin
      if (q1.size() == 0) chk("wr1_unexpected", {24'd0, addr1, data1}, 64'd0);
      else chk("wr1", {24'd0, addr1, data1}, {24'd0, q1.pop_front()});
    end
    if (we2 === 1'b1) begin
      if (q2.size() == 0) chk("wr2_unexpected", {30'd0, addr2, data2}, 64'd0);
      else chk("wr2", {30'd0, addr2, data2}, {30'd0, q2.pop_front()});
    end
    if (pipe_en1 === 1'b1) en_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; en_cnt = 0;
    rst1 = 1; flag_i1 = 0; step1 = 0; mode1 = 0; halted1 = 0; instr1 = '0;
    rst2 = 1; flag_i2 = 0; step2 = 0; mode2 = 0; halted2 = 0; instr2 = '0;
    tick(); tick();
    chk("rst_state", state1, 2'b00);
    chk("rst_pipe_reset", pipe_reset1, 1'b1);
    chk("rst_we", we1, 1'b0);
    chk("rst_en", pipe_en1, 1'b0);
    chk("rst_count", count1, 9'd0);
    chk("rst_err", err1, 1'b0);
    chk("rst_addr_data", {addr1, data1}, 40'd0);

    // 1: three back-to-back words ending in HALT
    rst1 = 0;
    flag_i1 = 1; instr1 = 32'h2001_0005; q1.push_back({8'd0, 32'h2001_0005}); tick();
    chk("t1_loading_state", state1, 2'b00);
    instr1 = 32'h2002_0003; q1.push_back({8'd1, 32'h2002_0003}); tick();
    instr1 = 32'hFFFF_FFFF; q1.push_back({8'd2, 32'hFFFF_FFFF}); tick();
    flag_i1 = 0;
    chk("t1_state_ready", state1, 2'b01);
    chk("t1_count", count1, 9'd3);
    chk("t1_pipe_reset", pipe_reset1, 1'b0);
    chk("t1_last_we", we1, 1'b1);
    tick();
    chk("t1_we_off", we1, 1'b0);

    // 3: single-step pulses, then held step
    en_cnt = 0;
    step1 = 1; tick();
    chk("t3_step_en", pipe_en1, 1'b1);
    step1 = 0; tick();
    chk("t3_step_en_off", pipe_en1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step1 = 1; tick();
      step1 = 0; tick(); tick();
    end
    chk("t3_three_pulses", en_cnt, 3);
    en_cnt = 0;
    step1 = 1;
    repeat (10) tick();
    step1 = 0; tick(); tick();
    chk("t3_held_one_pulse", en_cnt, 1);
    chk("t3_still_ready", state1, 2'b01);

    // 2: load with FLAG_I gaps
    rst1 = 1; tick(); rst1 = 0;
    flag_i1 = 1; instr1 = 32'hA000_0001; q1.push_back({8'd0, 32'hA000_0001}); tick();
    flag_i1 = 0; instr1 = 32'hDEAD_BEEF; tick();
    chk("t2_gap_we", we1, 1'b0);
    tick();
    chk("t2_gap_we2", we1, 1'b0);
    chk("t2_gap_count", count1, 9'd1);
    flag_i1 = 1; instr1 = 32'hA000_0002; q1.push_back({8'd1, 32'hA000_0002}); tick();
    instr1 = 32'hFFFF_FFFF; q1.push_back({8'd2, 32'hFFFF_FFFF}); tick();
    flag_i1 = 0;
    chk("t2_count", count1, 9'd3);
    chk("t2_state", state1, 2'b01);

    // 4: continuous mode then halt
    en_cnt = 0;
    mode1 = 1; tick();
    chk("t4_run_state", state1, 2'b10);
    for (int i = 0; i < 5; i++) begin
      chk("t4_run_en", pipe_en1, 1'b1);
      tick();
    end
    halted1 = 1; tick();
    halted1 = 0;
    chk("t4_halt_en", pipe_en1, 1'b0);
    chk("t4_done_state", state1, 2'b11);
    en_cnt = 0;
    mode1 = 0; step1 = 1; tick();
    step1 = 0; tick(); tick();
    chk("t4_done_no_step", en_cnt, 0);
    flag_i1 = 1; instr1 = 32'h1234_5678; tick();
    flag_i1 = 0; tick();
    chk("t4_done_err", err1, 1'b1);
    chk("t4_done_count", count1, 9'd3);

    // 6: reset mid-load restarts at address 0 and clears LOAD_ERR
    rst1 = 1; tick(); rst1 = 0;
    chk("t6_err_cleared", err1, 1'b0);
    flag_i1 = 1; instr1 = 32'hB000_0000; q1.push_back({8'd0, 32'hB000_0000}); tick();
    instr1 = 32'hB000_0001; q1.push_back({8'd1, 32'hB000_0001}); tick();
    flag_i1 = 0; rst1 = 1; tick();
    rst1 = 0;
    chk("t6_rst_count", count1, 9'd0);
    flag_i1 = 1; instr1 = 32'hC000_0000; q1.push_back({8'd0, 32'hC000_0000}); tick();
    instr1 = 32'hFFFF_FFFF; q1.push_back({8'd1, 32'hFFFF_FFFF}); tick();
    flag_i1 = 0;
    chk("t6_count", count1, 9'd2);
    chk("t6_err", err1, 1'b0);
    chk("t6_state", state1, 2'b01);
    tick();

    // halt beats a simultaneous step edge
    step1 = 1; halted1 = 1; tick();
    step1 = 0; halted1 = 0;
    chk("halt_vs_step_en", pipe_en1, 1'b0);
    chk("halt_vs_step_state", state1, 2'b11);
    tick();
    chk("halt_vs_step_en2", pipe_en1, 1'b0);

    // 5: ADDR_W=2 fills memory, extra words dropped
    rst2 = 1; tick(); rst2 = 0;
    for (int i = 0; i < 6; i++) begin
      flag_i2 = 1;
      instr2 = 32'h5000_0000 + 32'(i);
      if (i < 4) q2.push_back({2'(i), 32'h5000_0000 + 32'(i)});
      tick();
      if (i == 3) chk("t5_ready_after_4", state2, 2'b01);
    end
    flag_i2 = 0; tick();
    chk("t5_err", err2, 1'b1);
    chk("t5_count", count2, 3'd4);
    chk("t5_state", state2, 2'b01);
    chk("t5_we_off", we2, 1'b0);

    tick();
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
